// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Generates per-stage write enables and bubble strobes from hazard conditions,
// and sequences a drain of the pipeline when HLT is decoded, then holds it halted.
module pipe_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DRAIN_CYC = 3,
    parameter logic [3:0]  HLT_OP    = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_SrcReg1,
    input  logic [3:0]       id_SrcReg2,
    input  logic             id_uses_src2,
    input  logic             branch_taken,
    input  logic             ex_Data_Mem_en,
    input  logic             ex_Data_Mem_wr,
    input  logic             ex_WriteReg,
    input  logic [3:0]       ex_DstReg,
    input  logic             mem_access,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned     DCW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0]  DRAIN_INIT = DCW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t         state, state_next;
    logic [DCW-1:0] drain_cnt, drain_next;

    logic dstall, istall, luse, hlt_id;

    // Hazard conditions; a load in EX with a matching live source in ID is a load-use
    always_comb begin
        dstall = mem_access & ~dmem_ready;
        istall = ~imem_ready;
        luse   = ex_Data_Mem_en & ~ex_Data_Mem_wr & ex_WriteReg & (ex_DstReg != 4'd0) &
                 ((ex_DstReg == id_SrcReg1) | (id_uses_src2 & (ex_DstReg == id_SrcReg2)));
        hlt_id = (id_opcode == HLT_OP);
    end

    // State and drain counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Next state: HLT in ID starts the drain; drain counts only unfrozen cycles
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        unique case (state)
            RUN: begin
                if (!dstall && !luse && hlt_id) begin
                    state_next = DRAIN;
                    drain_next = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (!dstall) begin
                    if (drain_cnt == '0) state_next = HALT;
                    else                 drain_next = drain_cnt - DCW'(1);
                end
            end
            HALT: ;
            default: state_next = RUN;
        endcase
    end

    // Stage enables and flushes, prioritised dstall > luse > HLT > istall/branch
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        unique case (state)
            RUN: begin
                if (dstall) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end else if (luse) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (hlt_id) begin
                    // HLT itself moves on into ID/EX; nothing behind it is fetched
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end else if (branch_taken) begin
                    // Redirect is accepted even while the fetch is not ready
                    ifid_flush = 1'b1;
                end else if (istall) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            DRAIN: begin
                if (dstall) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end else begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            default: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
        endcase
    end

    // Halted flag is registered and follows the HALT state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) halted <= 1'b0;
        else      halted <= (state_next == HALT);
    end

    // Saturating count of RUN cycles in which fetch was frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && !pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a
// behavioural model of the stall/flush/drain rules.
module tb_pipe_ctrl;

    localparam int CW = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    id_opcode, id_SrcReg1, id_SrcReg2, ex_DstReg;
    logic          id_uses_src2, branch_taken, ex_Data_Mem_en, ex_Data_Mem_wr, ex_WriteReg;
    logic          mem_access, imem_ready, dmem_ready;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW), .DRAIN_CYC(DC), .HLT_OP(4'hF)) dut (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_SrcReg1(id_SrcReg1), .id_SrcReg2(id_SrcReg2),
        .id_uses_src2(id_uses_src2), .branch_taken(branch_taken),
        .ex_Data_Mem_en(ex_Data_Mem_en), .ex_Data_Mem_wr(ex_Data_Mem_wr),
        .ex_WriteReg(ex_WriteReg), .ex_DstReg(ex_DstReg),
        .mem_access(mem_access), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .halted(halted), .stall_cnt(stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = running, 1 = draining, 2 = halted
    int m_mode, m_rem, m_cnt, m_halted;
    int n_mode, n_rem, n_cnt, n_halted;
    logic [6:0] m_exp;

    function automatic bit f_dstall();
        return mem_access && !dmem_ready;
    endfunction

    function automatic bit f_luse();
        return ex_Data_Mem_en && !ex_Data_Mem_wr && ex_WriteReg && (ex_DstReg != 0) &&
               ((ex_DstReg == id_SrcReg1) || (id_uses_src2 && (ex_DstReg == id_SrcReg2)));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    function automatic logic [6:0] model_outs();
        if (m_mode == 2 || f_dstall()) return 7'b0000000;
        if (m_mode == 1)               return 7'b0111111;
        if (f_luse())                  return 7'b0001111;
        if (id_opcode == 4'hF)         return 7'b0111011;
        return {branch_taken | imem_ready, 1'b1, branch_taken | ~imem_ready, 4'b1011};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_cnt = 0; m_halted = 0;
        n_mode = 0; n_rem = 0; n_cnt = 0; n_halted = 0;
    endtask

    // Compare at the falling edge, then work out the model state for the next edge
    task automatic tick_begin();
        @(negedge clk);
        if (!rst) model_reset();
        m_exp = model_outs();
        chk("pc_en",      pc_en,      m_exp[6]);
        chk("ifid_en",    ifid_en,    m_exp[5]);
        chk("ifid_flush", ifid_flush, m_exp[4]);
        chk("idex_en",    idex_en,    m_exp[3]);
        chk("idex_flush", idex_flush, m_exp[2]);
        chk("exmem_en",   exmem_en,   m_exp[1]);
        chk("memwb_en",   memwb_en,   m_exp[0]);
        chk("halted",     halted,     m_halted);
        chk("stall_cnt",  stall_cnt,  m_cnt);
        n_mode = m_mode; n_rem = m_rem; n_cnt = m_cnt;
        if (rst) begin
            if (m_mode == 0) begin
                if (!m_exp[6] && m_cnt < (1 << CW) - 1) n_cnt = m_cnt + 1;
                if (!f_dstall() && !f_luse() && id_opcode == 4'hF) begin
                    n_mode = 1;
                    n_rem  = DC - 1;
                end
            end else if (m_mode == 1 && !f_dstall()) begin
                if (m_rem == 0) n_mode = 2;
                else            n_rem  = m_rem - 1;
            end
        end
        n_halted = (n_mode == 2) ? 1 : 0;
    endtask

    task automatic tick_end();
        @(posedge clk);
        #1;
        m_mode = n_mode; m_rem = n_rem; m_cnt = n_cnt; m_halted = n_halted;
        if (!rst) model_reset();
    endtask

    task automatic tick();
        tick_begin();
        tick_end();
    endtask

    task automatic set_idle();
        id_opcode = 4'h0; id_SrcReg1 = 4'h0; id_SrcReg2 = 4'h0; id_uses_src2 = 1'b0;
        branch_taken = 1'b0; ex_Data_Mem_en = 1'b0; ex_Data_Mem_wr = 1'b0;
        ex_WriteReg = 1'b0; ex_DstReg = 4'h0; mem_access = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
    endtask

    task automatic set_luse(input logic [3:0] r);
        ex_Data_Mem_en = 1'b1; ex_Data_Mem_wr = 1'b0; ex_WriteReg = 1'b1;
        ex_DstReg = r; id_SrcReg1 = r;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        tick_begin();
        chk("lit_rst_halted", halted, 0);
        chk("lit_rst_cnt", stall_cnt, 0);
        chk("lit_rst_pc_en", pc_en, 1);
        chk("lit_rst_flush", ifid_flush, 0);
        tick_end();
        rst = 1'b1;
    endtask

    int n_edges;
    int halt_wait;

    initial begin
        model_reset();
        do_reset();
        tick(); tick();

        // Load-use inserts one bubble
        set_luse(4'd3);
        tick_begin();
        chk("lit_luse_pc_en", pc_en, 0);
        chk("lit_luse_ifid_en", ifid_en, 0);
        chk("lit_luse_idex_flush", idex_flush, 1);
        tick_end();
        set_idle();
        tick_begin();
        chk("lit_after_luse_pc_en", pc_en, 1);
        chk("lit_after_luse_cnt", stall_cnt, 1);
        tick_end();

        // Register 0 never produces a load-use
        set_luse(4'd0);
        tick_begin();
        chk("lit_r0_pc_en", pc_en, 1);
        tick_end();
        set_idle();

        // Four-cycle data-memory freeze
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick_begin();
            chk("lit_freeze_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
            tick_end();
        end
        set_idle();
        tick_begin();
        chk("lit_unfreeze_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'h1f);
        chk("lit_freeze_cnt", stall_cnt, 5);
        tick_end();

        // Freeze overrides load-use
        set_luse(4'd5); mem_access = 1'b1; dmem_ready = 1'b0;
        tick_begin();
        chk("lit_freeze_luse_flush", idex_flush, 0);
        chk("lit_freeze_luse_idex_en", idex_en, 0);
        tick_end();
        set_idle();

        // Branch redirect accepted while fetch not ready
        branch_taken = 1'b1; imem_ready = 1'b0;
        tick_begin();
        chk("lit_br_istall_pc_en", pc_en, 1);
        chk("lit_br_istall_flush", ifid_flush, 1);
        tick_end();
        set_luse(4'd7);
        tick_begin();
        chk("lit_br_luse_pc_en", pc_en, 0);
        chk("lit_br_luse_idex_flush", idex_flush, 1);
        tick_end();
        set_idle();

        // HLT drains for three cycles, then halts
        id_opcode = 4'hF;
        tick_begin();
        chk("lit_hlt_pc_en", pc_en, 0);
        chk("lit_hlt_idex_flush", idex_flush, 0);
        tick_end();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            tick_begin();
            chk("lit_drain_pc_en", pc_en, 0);
            chk("lit_drain_idex_flush", idex_flush, 1);
            chk("lit_drain_halted", halted, 0);
            tick_end();
        end
        tick_begin();
        chk("lit_halt_halted", halted, 1);
        chk("lit_halt_flush", ifid_flush, 0);
        chk("lit_halt_cnt", stall_cnt, 8);
        tick_end();
        do_reset();

        // HLT with a two-cycle freeze during the drain halts two edges later
        id_opcode = 4'hF;
        tick();
        set_idle();
        tick();
        mem_access = 1'b1; dmem_ready = 1'b0;
        tick(); tick();
        set_idle();
        n_edges = 4;
        while (n_edges < 20) begin
            tick_begin();
            if (halted) break;
            tick_end();
            n_edges++;
        end
        chk("lit_halt_delay_edges", n_edges, 6);
        tick_end();
        do_reset();

        // Counter saturation
        imem_ready = 1'b0;
        for (int i = 0; i < (1 << CW) + 5; i++) tick();
        set_idle();
        tick_begin();
        chk("lit_sat_cnt", stall_cnt, 15);
        tick_end();
        do_reset();

        // Randomized traffic
        halt_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_halted != 0) halt_wait++;
            else               halt_wait = 0;
            rst = (halt_wait >= 3 || $urandom_range(299) == 0) ? 1'b0 : 1'b1;
            if (!rst) halt_wait = 0;
            id_opcode      = ($urandom_range(39) == 0) ? 4'hF : 4'($urandom_range(14));
            id_SrcReg1     = 4'($urandom_range(3));
            id_SrcReg2     = 4'($urandom_range(3));
            id_uses_src2   = 1'($urandom_range(1));
            branch_taken   = ($urandom_range(4) == 0);
            ex_Data_Mem_en = 1'($urandom_range(1));
            ex_Data_Mem_wr = ($urandom_range(2) == 0);
            ex_WriteReg    = ($urandom_range(3) != 0);
            ex_DstReg      = 4'($urandom_range(3));
            mem_access     = ($urandom_range(2) == 0);
            imem_ready     = ($urandom_range(4) != 0);
            dmem_ready     = ($urandom_range(2) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
